rvv_backend_alu_result_queue: RTL
=================================

# rvv_backend_alu_result_queue

Parametrised in-order result stage between the ALU execution logic and the ROB. It accepts two kinds of uop: single-cycle results that are already final, and two-stage mask uops (OP_VIOTA/OP_VCPOP) that still need second-stage execution. Both kinds go into a DEPTH-entry FIFO and drain to the ROB strictly in order under ready/valid backpressure. An optional empty-queue bypass gives single-cycle results zero added latency.

## Interface
- DEPTH, 2, number of queue entries (≥1)
- BYPASS, 1, 1 = single-cycle result may go straight to ROB when queue is empty; 0 = every result is registered
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- uop_valid  input  1  a completed first-stage uop is offered
- uop_multi  input  1  uop needs second-stage execution (uop_p1data is meaningful)
- uop_result  input  PU2ROB_t  final result, meaningful when !uop_multi
- uop_p1data  input  PIPE_DATA_t  first-stage data, meaningful when uop_multi
- pop_rs  output  1  uop accepted this cycle; reservation station pops
- result_valid  output  1  result offered to ROB
- result  output  PU2ROB_t  result to ROB
- result_ready  input  1  ROB accepts result
- occupancy  output  $clog2(DEPTH+1)  current number of valid entries

## Operation
- Entry contents: multi flag, PU2ROB_t, PIPE_DATA_t. Only the field selected by the multi flag is written. The unused field keeps its old value (low power).
- deq = result_valid & result_ready; full = (count==DEPTH).
- pop_rs = uop_valid & (!full | deq). Same-cycle enqueue and dequeue are allowed when full.
- Head output when count>0:
  - result_valid = 1.
  - result = head.multi ? exec_p1(head.p1data) : head.result.
  - exec_p1 is purely combinational.
- Bypass (BYPASS=1, count==0, uop_valid, !uop_multi):
  - result_valid = 1 and result = uop_result.
  - If result_ready, nothing is stored and count stays 0.
  - Otherwise the uop is enqueued and presented from the queue next cycle.
- Multi uops are always enqueued and never bypassed.
- count==0 with no bypass: result_valid = 0 and result = '0.
- Enqueue writes at wr_ptr; dequeue advances rd_ptr. Pointers wrap modulo DEPTH, with no power-of-two requirement. count = count + enq − deq.
- Ordering is strict FIFO. A newer single-cycle result never overtakes an older multi uop.
- While result_valid=1 and result_ready=0, result must stay bit-stable.

## Timing
- Reset values: count=0, rd_ptr=wr_ptr=0, occupancy=0, result_valid=0, pop_rs=0 (when uop_valid=0), result='0. Entry payloads are also cleared.
- Latency:
  - Bypassed single-cycle result: 0 cycles.
  - Queued uop: 1 cycle minimum, from pop_rs to result_valid at the head.
- Throughput: 1 uop/cycle sustained with result_ready held high, including a stream of multi uops.
- pop_rs depends combinationally on result_ready only when full. Otherwise it depends on uop_valid only.
- Reset asserted mid-operation: all entries are discarded immediately. Outputs return to reset values asynchronously.

## Structure
- Shared package (rvv_backend.svh) holds:
  - PU2ROB_t and PIPE_DATA_t, already defined there.
  - New ALU_RQ_ENTRY_t {multi, PU2ROB_t res, PIPE_DATA_t p1}.
  - OP_VIOTA / OP_VCPOP encodings.
- Sub-module: rvv_backend_alu_unit_execution_p1 (combinational second stage), instanced once on the head entry.
- Registers use edff for pointers/count and always_ff with enable for entry payloads.

## Test plan
- DEPTH=2, BYPASS=1, ready=1, single-cycle uop with rob_entry=5 -> result_valid same cycle, result.rob_entry=5, pop_rs=1, occupancy stays 0.
- Multi uop OP_VCPOP on an all-ones 128-bit mask, ready=1 -> result one cycle after pop_rs, w_data=128, occupancy 1 then 0.
- ready=0, four single-cycle uops offered back-to-back (rob 1..4) -> pop_rs for rob 1,2 only, then 0, occupancy=2. Raise ready -> results emerge in order 1,2,3,4 with no gaps.
- Full queue, ready=1, uop_valid=1 -> simultaneous enqueue/dequeue, pop_rs=1, occupancy stays 2. Run 10 cycles to check wrap for DEPTH=3.
- Older multi uop (rob 7) queued, newer single-cycle (rob 8) offered -> no bypass, results ordered 7 then 8.
- rst_n pulsed low with occupancy=2 -> occupancy=0 and result_valid=0 immediately. First uop after reset behaves as in the first scenario.

Source files
------------

// File: rtl/rvv_backend_alu_result_queue_pkg.sv
// -----------------------------------------------------------------------------
// rvv_backend_alu_result_queue_pkg
//
// Shared types for the ALU result queue and its second-stage execution unit:
//   PU2ROB_t        - result handed to the ROB
//   PIPE_DATA_t     - first-stage data for two-stage mask uops
//   ALU_RQ_ENTRY_t  - one queue entry {multi, res, p1}
//   alu_op_e        - encodings of the two-stage mask operations
//   active_mask()   - body/mask-enable vector used by the mask operations
// -----------------------------------------------------------------------------
package rvv_backend_alu_result_queue_pkg;

    localparam int VLEN      = 128;
    localparam int VLENB     = VLEN / 8;
    localparam int SEW_W     = 8;                 // viota element width
    localparam int ROB_IDX_W = 4;
    localparam int VL_W      = $clog2(VLEN + 1);  // vl ranges 0..VLEN

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_VIOTA = 2'd1,
        OP_VCPOP = 2'd2
    } alu_op_e;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_entry;
        logic                 w_valid;
        logic [VLEN-1:0]      w_data;
        logic                 vxsat;
    } PU2ROB_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_entry;
        alu_op_e              uop_funct;
        logic                 vm;        // 1 = unmasked
        logic [VL_W-1:0]      vl;
        logic [VLEN-1:0]      vs2_data;  // source mask
        logic [VLEN-1:0]      v0_data;   // mask register v0
    } PIPE_DATA_t;

    typedef struct packed {
        logic       multi;
        PU2ROB_t    res;
        PIPE_DATA_t p1;
    } ALU_RQ_ENTRY_t;

    // Bit i is set when element/bit i lies in the body (i < vl) and is
    // enabled by the mask (vm or v0[i]).
    function automatic logic [VLEN-1:0] active_mask(
        input logic            vm,
        input logic [VLEN-1:0] v0,
        input logic [VL_W-1:0] vl
    );
        logic [VLEN-1:0] m;
        m = '0;
        for (int i = 0; i < VLEN; i++) begin
            m[i] = (VL_W'(i) < vl) && (vm || v0[i]);
        end
        return m;
    endfunction

endpackage

// File: rtl/rvv_backend_alu_result_queue_exec_p1.sv
// -----------------------------------------------------------------------------
// rvv_backend_alu_unit_execution_p1
//
// Purely combinational second stage for two-stage mask uops.
//   OP_VCPOP : w_data = number of active set bits of vs2
//   OP_VIOTA : each active SEW=8 element i gets the count of active set
//              bits of vs2 below i; inactive and tail elements read 0
//   other    : w_data = 0
//
// Ports:
//   p1_i      in   first-stage data of the head entry
//   result_o  out  final ROB result
// -----------------------------------------------------------------------------
module rvv_backend_alu_unit_execution_p1
    import rvv_backend_alu_result_queue_pkg::*;
(
    input  PIPE_DATA_t p1_i,
    output PU2ROB_t    result_o
);

    logic [VLEN-1:0] active;
    logic [VLEN-1:0] set_bits;
    logic [VL_W-1:0] pop_cnt;
    logic [VL_W-1:0] run_cnt;
    logic [VLEN-1:0] iota_data;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned (no latch); blocking assignments let the
        // running counters accumulate within the loop.
        active    = active_mask(p1_i.vm, p1_i.v0_data, p1_i.vl);
        set_bits  = p1_i.vs2_data & active;
        pop_cnt   = '0;
        run_cnt   = '0;
        iota_data = '0;

        for (int i = 0; i < VLEN; i++) begin
            pop_cnt = pop_cnt + VL_W'(set_bits[i]);
        end

        // Exclusive prefix count: element i sees only bits strictly below it.
        for (int i = 0; i < VLENB; i++) begin
            if (active[i]) begin
                iota_data[i*SEW_W +: SEW_W] = run_cnt[SEW_W-1:0];
            end
            run_cnt = run_cnt + VL_W'(set_bits[i]);
        end

        result_o           = '0;
        result_o.rob_entry = p1_i.rob_entry;
        result_o.w_valid   = 1'b1;
        case (p1_i.uop_funct)
            OP_VIOTA: result_o.w_data = iota_data;
            OP_VCPOP: result_o.w_data = VLEN'(pop_cnt);
            default:  result_o.w_data = '0;
        endcase
    end

endmodule

// File: rtl/rvv_backend_alu_result_queue.sv
// -----------------------------------------------------------------------------
// rvv_backend_alu_result_queue
//
// In-order result stage between ALU execution and the ROB. Single-cycle
// results and two-stage mask uops share one DEPTH-entry FIFO; the second
// stage runs combinationally on the head entry. With BYPASS=1 a single-cycle
// result offered to an empty queue is presented to the ROB in the same cycle.
//
// Parameters:
//   DEPTH   number of entries (>= 1, any value, no power-of-two requirement)
//   BYPASS  1 = empty-queue bypass for single-cycle results
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   uop_valid      first-stage uop offered
//   uop_multi      uop needs second-stage execution
//   uop_result     final result (single-cycle uop)
//   uop_p1data     first-stage data (multi uop)
//   pop_rs         uop accepted this cycle
//   result_valid   result offered to ROB
//   result         result to ROB
//   result_ready   ROB accepts result
//   occupancy      number of valid entries
// -----------------------------------------------------------------------------
module rvv_backend_alu_result_queue
    import rvv_backend_alu_result_queue_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b1
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         uop_valid,
    input  logic                         uop_multi,
    input  PU2ROB_t                      uop_result,
    input  PIPE_DATA_t                   uop_p1data,
    output logic                         pop_rs,
    output logic                         result_valid,
    output PU2ROB_t                      result,
    input  logic                         result_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] count_q,  count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    ALU_RQ_ENTRY_t    entry_q [DEPTH];
    ALU_RQ_ENTRY_t    head;
    PU2ROB_t          head_exec_res;

    logic             empty;
    logic             full;
    logic             bypass_offer;
    logic             deq;
    logic             q_deq;
    logic             enq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    // Multi uops never bypass, so an older queued multi uop can never be
    // overtaken: bypass is only possible when the queue is empty.
    assign bypass_offer = BYPASS && empty && uop_valid && !uop_multi;
    assign head         = entry_q[rd_ptr_q];

    rvv_backend_alu_unit_execution_p1 u_exec_p1 (
        .p1_i     (head.p1),
        .result_o (head_exec_res)
    );

    // Output mux: queue head has priority; bypass only when empty.
    always_comb begin
        result_valid = !empty || bypass_offer;
        result       = '0;
        if (!empty) begin
            result = head.multi ? head_exec_res : head.res;
        end else if (bypass_offer) begin
            result = uop_result;
        end
    end

    // When not full, pop_rs is independent of result_ready.
    assign deq    = result_valid && result_ready;
    assign q_deq  = deq && !empty;
    assign pop_rs = uop_valid && (!full || deq);
    // A bypassed result accepted by the ROB is never stored.
    assign enq    = pop_rs && !(bypass_offer && result_ready);

    always_comb begin
        count_d  = count_q + CNT_W'(enq) - CNT_W'(q_deq);
        rd_ptr_d = q_deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = enq   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (enq || q_deq) begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // NOTE: the payload array is cleared on reset so that the head (and the
    // combinational second stage fed from it) starts from known values.
    // Only the field selected by the multi flag is written; the other field
    // keeps its old contents to avoid needless toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (enq) begin
            entry_q[wr_ptr_q].multi <= uop_multi;
            if (uop_multi) begin
                entry_q[wr_ptr_q].p1  <= uop_p1data;
            end else begin
                entry_q[wr_ptr_q].res <= uop_result;
            end
        end
    end

    assign occupancy = count_q;

endmodule
